shift_ser: RTL and testbench

SHIFT_SER -- requirements
Module: shift_ser

---
 rtl/shift_ser.sv | 85 ++++++++
 tb/tb_shift_ser.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/shift_ser.sv
// shift_ser: parallel-load serializer/deserializer with variable beat count, LSB/MSB-first order.
// Build option: define SHIFT_SER_LOOPBACK_EN to compile in the lpbk_i rotate path.
module shift_ser #(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_NUM = 1,
  localparam int BEAT_NUM = DATA_WIDTH / LANE_NUM,
  localparam int CNT_WIDTH = $clog2(BEAT_NUM) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dir_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic                  tick_i,
  input  logic                  abort_i,
  input  logic                  lpbk_i,
  input  logic                  par_valid_i,
  output logic                  par_ready_o,
  input  logic [DATA_WIDTH-1:0] par_data_i,
  input  logic [LANE_NUM-1:0]   ser_dat_i,
  output logic [LANE_NUM-1:0]   ser_dat_o,
  output logic                  ser_vld_o,
  output logic [DATA_WIDTH-1:0] par_data_o,
  output logic                  par_valid_o,
  output logic                  busy_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, len_ld;
  logic dir_q, dir_d;
  logic [LANE_NUM-1:0] rx;
  logic [DATA_WIDTH+LANE_NUM-1:0] cat_l, cat_r;
`ifdef SHIFT_SER_LOOPBACK_EN
  assign rx = lpbk_i ? ser_dat_o : ser_dat_i;
`else
  logic unused_lpbk;
  assign unused_lpbk = lpbk_i;
  assign rx = ser_dat_i;
`endif
  // Wide concatenations keep the shifts legal even when LANE_NUM equals DATA_WIDTH
  assign cat_l = {shreg_q, rx};
  assign cat_r = {rx, shreg_q};
  assign len_ld = (len_i == '0 || len_i > CNT_WIDTH'(BEAT_NUM)) ? CNT_WIDTH'(BEAT_NUM) : len_i;
  assign par_ready_o = state_q == IDLE;
  assign ser_vld_o = state_q == SHIFT;
  assign par_valid_o = state_q == DONE;
  assign busy_o = state_q != IDLE;
  assign par_data_o = shreg_q;
  assign ser_dat_o = state_q != SHIFT ? '0 :
                     dir_q ? shreg_q[LANE_NUM-1:0] : shreg_q[DATA_WIDTH-1-:LANE_NUM];
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    case (state_q)
      IDLE: if (par_valid_i) begin
        state_d = SHIFT;
        shreg_d = par_data_i;
        dir_d = dir_i;
        cnt_d = len_ld;
      end
      SHIFT: if (abort_i) state_d = IDLE;
      else if (tick_i) begin
        shreg_d = dir_q ? cat_r[DATA_WIDTH+LANE_NUM-1:LANE_NUM] : cat_l[DATA_WIDTH-1:0];
        cnt_d = cnt_q - CNT_WIDTH'(1);
        state_d = cnt_q == CNT_WIDTH'(1) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end
endmodule

// File: tb/tb_shift_ser.sv
// tb_shift_ser: directed checks of shift_ser on an 8x1 and a 32x4 instance.
module tb_shift_ser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic dir8 = 0, tick8 = 0, abort8 = 0, lpbk8 = 0, pv8 = 0;
  logic [3:0] len8 = '0;
  logic [7:0] pd8 = '0;
  logic [0:0] sdi8 = '0;
  logic pr8, svld8, pvo8, busy8;
  logic [0:0] sdo8;
  logic [7:0] pdo8;
  logic dir32 = 0, tick32 = 0, abort32 = 0, lpbk32 = 0, pv32 = 0;
  logic [3:0] len32 = '0;
  logic [31:0] pd32 = '0;
  logic [3:0] sdi32 = '0;
  logic pr32, svld32, pvo32, busy32;
  logic [3:0] sdo32;
  logic [31:0] pdo32;
  logic [7:0] e8;
  logic [7:0] a5;

  always #5 clk = ~clk;

  shift_ser #(.DATA_WIDTH(8), .LANE_NUM(1)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .dir_i(dir8), .len_i(len8), .tick_i(tick8),
    .abort_i(abort8), .lpbk_i(lpbk8), .par_valid_i(pv8), .par_ready_o(pr8),
    .par_data_i(pd8), .ser_dat_i(sdi8), .ser_dat_o(sdo8), .ser_vld_o(svld8),
    .par_data_o(pdo8), .par_valid_o(pvo8), .busy_o(busy8));

  shift_ser #(.DATA_WIDTH(32), .LANE_NUM(4)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .dir_i(dir32), .len_i(len32), .tick_i(tick32),
    .abort_i(abort32), .lpbk_i(lpbk32), .par_valid_i(pv32), .par_ready_o(pr32),
    .par_data_i(pd32), .ser_dat_i(sdi32), .ser_dat_o(sdo32), .ser_vld_o(svld32),
    .par_data_o(pdo32), .par_valid_o(pvo32), .busy_o(busy32));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset8(input string tag);
    check({tag, "_ready"}, 32'(pr8), 1);
    check({tag, "_vld"}, 32'(svld8), 0);
    check({tag, "_sdo"}, 32'(sdo8), 0);
    check({tag, "_pdo"}, 32'(pdo8), 0);
    check({tag, "_pvo"}, 32'(pvo8), 0);
    check({tag, "_busy"}, 32'(busy8), 0);
  endtask

  initial begin
    step();
    step();
    check_reset8("rst");
    rst = 0;
    // MSB-first full transfer, len 0 means all 8 beats
    a5 = 8'hA5;
    pd8 = 8'hA5; dir8 = 0; len8 = 0; pv8 = 1; tick8 = 1; sdi8 = 1;
    step();
    pv8 = 0;
    for (int i = 0; i < 8; i++) begin
      check("a_sdo", 32'(sdo8), 32'(a5[7-i]));
      check("a_vld", 32'(svld8), 1);
      check("a_pvo", 32'(pvo8), 0);
      step();
    end
    check("a_done_pvo", 32'(pvo8), 1);
    check("a_done_pdo", 32'(pdo8), 32'hFF);
    check("a_done_busy", 32'(busy8), 1);
    step();
    check("a_idle_pvo", 32'(pvo8), 0);
    check("a_idle_ready", 32'(pr8), 1);
    // Back-to-back load, LSB-first with gapped ticks
    pd8 = 8'h3C; dir8 = 1; len8 = 8; pv8 = 1; sdi8 = 1; tick8 = 0;
    step();
    pv8 = 0;
    check("c_ready", 32'(pr8), 0);
    check("c_load", 32'(pdo8), 32'h3C);
    e8 = 8'h3C;
    for (int k = 0; k < 16; k++) begin
      tick8 = (k % 2 == 0);
      step();
      if (k % 2 == 0) e8 = {1'b1, e8[7:1]};
      check("c_pdo", 32'(pdo8), 32'(e8));
      check("c_pvo", 32'(pvo8), 32'(k == 14));
    end
    // Abort after three beats; a mid-transfer load request must be ignored
    pd8 = 8'hF0; dir8 = 0; len8 = 0; pv8 = 1; tick8 = 1; sdi8 = 0;
    step();
    pd8 = 8'h55;
    for (int i = 0; i < 3; i++) step();
    check("d_partial", 32'(pdo8), 32'h80);
    pv8 = 0; abort8 = 1;
    step();
    abort8 = 0; tick8 = 0;
    check("d_ready", 32'(pr8), 1);
    check("d_busy", 32'(busy8), 0);
    check("d_pvo", 32'(pvo8), 0);
    check("d_hold", 32'(pdo8), 32'h80);
    step();
    check("d_nopulse", 32'(pvo8), 0);
    // Single-beat transfer with loopback request
    pd8 = 8'h81; dir8 = 0; len8 = 1; lpbk8 = 1; sdi8 = 0; pv8 = 1; tick8 = 1;
    step();
    pv8 = 0;
    step();
    check("e_pvo", 32'(pvo8), 1);
`ifdef SHIFT_SER_LOOPBACK_EN
    check("e_pdo", 32'(pdo8), 32'h03);
`else
    check("e_pdo", 32'(pdo8), 32'h02);
`endif
    lpbk8 = 0;
    step();
    // Reset in the middle of a transfer, together with tick and load
    pd8 = 8'hA5; dir8 = 0; len8 = 0; pv8 = 1; tick8 = 1; sdi8 = 1;
    step();
    pv8 = 0;
    step();
    check("f_mid", 32'(pdo8), 32'h4B);
    rst = 1; pv8 = 1;
    step();
    check_reset8("f_rst");
    rst = 0; pv8 = 0; tick8 = 0;
    step();
    // 32x4 LSB-first partial transfer
    pd32 = 32'h12345678; dir32 = 1; len32 = 3; sdi32 = 4'hF; pv32 = 1; tick32 = 1;
    step();
    pv32 = 0;
    check("g_sdo0", 32'(sdo32), 8);
    step();
    check("g_sdo1", 32'(sdo32), 7);
    step();
    check("g_sdo2", 32'(sdo32), 6);
    step();
    check("g_pvo", 32'(pvo32), 1);
    check("g_pdo", pdo32, 32'hFFF12345);
    step();
    // Oversized length clamps to the full 8 beats
    pd32 = 32'h0; dir32 = 0; len32 = 15; pv32 = 1;
    step();
    pv32 = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("h_pvo", 32'(pvo32), 32'(i == 8));
    end
    check("h_pdo", pdo32, 32'hFFFFFFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
